// File: rtl/accum_eot_pkg.sv
// Shared types and helpers for the accum_eot reduction stage.
// sat_add is only referenced when ACCUM_EOT_SAT_EN is defined.
package accum_eot_pkg;

  localparam int unsigned DIN_W_DEF  = 16;
  localparam int unsigned DOUT_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Default-width views of the stream payloads; the eot flag is the MSB of din.
  typedef struct packed {
    logic                  eot;
    logic [DIN_W_DEF-1:0]  data;
  } din_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  cnt;
    logic [DOUT_W_DEF-1:0] sum;
  } dout_t;

  // Unsigned add clamped to 2^w-1; operands are zero-extended to 64 bits by the caller.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/accum_eot_out_reg.sv
// dti_out_reg: single-entry registered dti producer with load/valid/ready.
// Reusable by any reduction stage that emits one result per transaction.
module dti_out_reg #(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         can_load,
  output logic         dout_valid,
  output logic [W-1:0] dout_data,
  input  logic         dout_ready
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  // A load is accepted whenever the slot is empty or being drained this cycle.
  assign can_load   = !valid_reg | dout_ready;
  assign dout_valid = valid_reg;
  assign dout_data  = data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && dout_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/accum_eot.sv
// accum_eot: sums and counts the words of each eot-terminated transaction
// and emits one {cnt, sum} result. Define ACCUM_EOT_SAT_EN for saturating arithmetic.
module accum_eot
  import accum_eot_pkg::*;
#(
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned DOUT_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_W:0]          din_data,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [CNT_W+DOUT_W-1:0] dout_data,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  logic [DOUT_W-1:0] acc_reg;
  logic [DOUT_W-1:0] acc_next;
  logic [DOUT_W-1:0] data_ext;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              din_eot;
  logic              din_hs;
  logic              load;
  logic              can_load;

  assign din_eot  = din_data[DIN_W];
  assign data_ext = DOUT_W'(din_data[DIN_W-1:0]);

`ifdef ACCUM_EOT_SAT_EN
  // Clamping at the maximum keeps the value pinned until the eot reload clears it.
  assign acc_next = DOUT_W'(sat_add(64'(acc_reg), 64'(data_ext), DOUT_W));
  assign cnt_next = CNT_W'(sat_add(64'(cnt_reg), 64'd1, CNT_W));
`else
  assign acc_next = acc_reg + data_ext;
  assign cnt_next = cnt_reg + CNT_W'(1);
`endif

  assign din_ready = can_load;
  assign din_hs    = din_valid & din_ready;
  assign load      = din_hs & din_eot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (din_hs) begin
      if (din_eot) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_next;
      end
    end
  end

  dti_out_reg #(
    .W(CNT_W + DOUT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  ({cnt_next, acc_next}),
    .can_load   (can_load),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready)
  );

endmodule
